// File: rtl/fft_pkg.sv
// fft_pkg: shared types, FSM states and elaboration-time helpers for the iterative FFT
package fft_pkg;

    localparam int  CPLX_W = 32;
    localparam real PI     = 3.14159265358979323846;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {LOAD, CALC, OUT} state_t;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int bitrev(input int v, input int bits);
        int r = 0;
        for (int i = 0; i < bits; i++) r |= ((v >> i) & 1) << (bits - 1 - i);
        return r;
    endfunction

    function automatic int tw_round(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    function automatic int tw_cos(input int idx, input int n, input int tw_w);
        return tw_round($cos(2.0 * PI * real'(idx) / real'(n)) * real'(1 << (tw_w - 2)));
    endfunction

    function automatic int tw_sin(input int idx, input int n, input int tw_w);
        return tw_round($sin(2.0 * PI * real'(idx) / real'(n)) * real'(1 << (tw_w - 2)));
    endfunction

endpackage

// File: rtl/fft_radix2_iter_if.sv
// fft_radix2_iter_if: sample-in / bin-out stream bundle with frame mode controls
interface fft_radix2_iter_if #(parameter int DATA_W = 32);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_real;
    logic signed [DATA_W-1:0] in_imag;
    logic                     inverse;
    logic                     scale;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_real;
    logic signed [DATA_W-1:0] out_imag;
    logic                     out_last;
    logic                     busy;

    modport master (
        output in_valid, in_real, in_imag, inverse, scale, out_ready,
        input  in_ready, out_valid, out_real, out_imag, out_last, busy
    );

    modport slave (
        input  in_valid, in_real, in_imag, inverse, scale, out_ready,
        output in_ready, out_valid, out_real, out_imag, out_last, busy
    );
endinterface

// File: rtl/fft_twiddle_rom.sv
// fft_twiddle_rom: N/2-entry twiddle table, conjugated for inverse transforms
module fft_twiddle_rom
    import fft_pkg::*;
#(
    parameter int N_POINTS = 8,
    parameter int TW_W     = 16,
    parameter int AW       = clog2(N_POINTS) - 1
) (
    input  logic [AW-1:0]          idx,
    input  logic                   inverse,
    output logic signed [TW_W-1:0] w_re,
    output logic signed [TW_W-1:0] w_im
);

    logic signed [TW_W-1:0] cos_tab [N_POINTS/2];
    logic signed [TW_W-1:0] sin_tab [N_POINTS/2];

    for (genvar i = 0; i < N_POINTS/2; i++) begin : g_tab
        localparam int C = tw_cos(i, N_POINTS, TW_W);
        localparam int S = tw_sin(i, N_POINTS, TW_W);
        assign cos_tab[i] = TW_W'(C);
        assign sin_tab[i] = TW_W'(S);
    end

    // W = cos - j*sin forward; the conjugate flips the imaginary sign
    always_comb begin
        w_re = cos_tab[idx];
        w_im = inverse ? sin_tab[idx] : -sin_tab[idx];
    end

endmodule

// File: rtl/fft_radix2_iter.sv
// fft_radix2_iter: in-place radix-2 DIT FFT/IFFT on a flop-array memory with one shared butterfly
module fft_radix2_iter
    import fft_pkg::*;
#(
    parameter int N_POINTS = 8,
    parameter int DATA_W   = 32,
    parameter int TW_W     = 16
) (
    input logic clk,
    input logic rst,
    fft_radix2_iter_if.slave bus
);

    localparam int LW = clog2(N_POINTS);
    localparam int SW = clog2(LW) + 1;
    localparam int PW = DATA_W + TW_W + 1;
    localparam logic [LW-1:0]        CNT_MAX = LW'(N_POINTS - 1);
    localparam logic [LW-2:0]        J_MAX   = (LW-1)'(N_POINTS/2 - 1);
    localparam logic [SW-1:0]        S_MAX   = SW'(LW - 1);
    localparam logic signed [PW-1:0] RND     = PW'(1) <<< (TW_W - 3);

    state_t                   state, state_nx;
    logic [LW-1:0]            cnt;
    logic [LW-2:0]            j;
    logic [SW-1:0]            s;
    logic                     inv, scl;
    logic                     in_fire, out_fire, calc_done;
    logic [LW-1:0]            half, kk, ua, ba;
    logic [LW-2:0]            tw_idx;
    logic signed [TW_W-1:0]   w_re, w_im;
    logic signed [PW-1:0]     pr, pi;
    logic signed [DATA_W:0]   p_re, p_im, su_re, su_im, sd_re, sd_im;
    logic signed [DATA_W-1:0] nu_re, nu_im, nd_re, nd_im;
    logic signed [DATA_W-1:0] mem_re [N_POINTS];
    logic signed [DATA_W-1:0] mem_im [N_POINTS];

    assign in_fire   = bus.in_valid && state == LOAD;
    assign out_fire  = bus.out_ready && state == OUT;
    assign calc_done = s == S_MAX && j == J_MAX;

    fft_twiddle_rom #(.N_POINTS(N_POINTS), .TW_W(TW_W)) u_rom (
        .idx(tw_idx), .inverse(inv), .w_re(w_re), .w_im(w_im)
    );

    // State register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= LOAD;
        else     state <= state_nx;

    // Next state and stream outputs; output data is forced to zero outside OUT
    always_comb begin
        state_nx = (state == LOAD && in_fire && cnt == CNT_MAX) ? CALC :
                   (state == CALC && calc_done)                 ? OUT  :
                   (state == OUT && out_fire && cnt == CNT_MAX) ? LOAD : state;
        bus.in_ready  = state == LOAD;
        bus.out_valid = state == OUT;
        bus.out_last  = state == OUT && cnt == CNT_MAX;
        bus.busy      = state != LOAD;
        bus.out_real  = state == OUT ? mem_re[cnt] : '0;
        bus.out_imag  = state == OUT ? mem_im[cnt] : '0;
    end

    // Sample/bin counter, butterfly and stage indices, per-frame mode latches
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt <= '0;
            j   <= '0;
            s   <= '0;
            inv <= 1'b0;
            scl <= 1'b0;
        end else begin
            if (in_fire && cnt == '0) begin
                inv <= bus.inverse;
                scl <= bus.scale;
            end
            if (in_fire || out_fire) cnt <= cnt + 1'b1;
            if (state == CALC) begin
                j <= j + 1'b1;
                if (j == J_MAX) s <= calc_done ? '0 : s + 1'b1;
            end
        end

    // Butterfly addressing, twiddled product with half-LSB rounding, sum/difference and optional halving
    always_comb begin
        half   = LW'(1) << s;
        kk     = {1'b0, j} & (half - 1'b1);
        ua     = (({1'b0, j} >> s) << (s + 1'b1)) | kk;
        ba     = ua | half;
        tw_idx = (LW-1)'(kk << (S_MAX - s));
        pr     = PW'(mem_re[ba]) * PW'(w_re) - PW'(mem_im[ba]) * PW'(w_im);
        pi     = PW'(mem_re[ba]) * PW'(w_im) + PW'(mem_im[ba]) * PW'(w_re);
        p_re   = (DATA_W+1)'((pr + RND) >>> (TW_W - 2));
        p_im   = (DATA_W+1)'((pi + RND) >>> (TW_W - 2));
        su_re  = (DATA_W+1)'(mem_re[ua]) + p_re;
        su_im  = (DATA_W+1)'(mem_im[ua]) + p_im;
        sd_re  = (DATA_W+1)'(mem_re[ua]) - p_re;
        sd_im  = (DATA_W+1)'(mem_im[ua]) - p_im;
        nu_re  = scl ? DATA_W'(su_re >>> 1) : DATA_W'(su_re);
        nu_im  = scl ? DATA_W'(su_im >>> 1) : DATA_W'(su_im);
        nd_re  = scl ? DATA_W'(sd_re >>> 1) : DATA_W'(sd_re);
        nd_im  = scl ? DATA_W'(sd_im >>> 1) : DATA_W'(sd_im);
    end

    // Memory: bit-reversed sample writes during LOAD, in-place butterfly writes during CALC
    always_ff @(posedge clk)
        if (in_fire) begin
            mem_re[LW'(bitrev(int'(cnt), LW))] <= bus.in_real;
            mem_im[LW'(bitrev(int'(cnt), LW))] <= bus.in_imag;
        end else if (state == CALC) begin
            mem_re[ua] <= nu_re;
            mem_im[ua] <= nu_im;
            mem_re[ba] <= nd_re;
            mem_im[ba] <= nd_im;
        end

endmodule

// File: tb/tb_fft_radix2_iter.sv
// tb_fft_radix2_iter: directed frames with a queue-based scoreboard and an independent output monitor
module tb_fft_radix2_iter;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int TW = 16;

    typedef struct {
        int   re;
        int   im;
        logic last;
        int   tol;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   bp  = 1'b0;
    int   checks = 0;
    int   passes = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fft_radix2_iter_if #(.DATA_W(DW)) bus ();

    fft_radix2_iter #(.N_POINTS(N), .DATA_W(DW), .TW_W(TW)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    task automatic chk(input string name, input int act, input int req, input int tol);
        checks++;
        if (act >= req - tol && act <= req + tol) passes++;
        else $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", name, act, req, tol, $time);
    endtask

    task automatic push_exp(input int re[N], input int im[N], input int tol);
        for (int i = 0; i < N; i++) sb.push_back('{re[i], im[i], logic'(i == N - 1), tol});
    endtask

    task automatic send(input int re[N], input int im[N], input bit inv, input bit scl, input bit meas);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_frame", int'(bus.in_ready), 1, 0);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_real  = re[i];
            bus.in_imag  = im[i];
            bus.inverse  = inv;
            bus.scale    = scl;
            @(posedge clk);
        end
        #1;
        bus.in_valid = 1'b0;
        chk("in_ready_drop", int'(bus.in_ready), 0, 0);
        if (meas) begin
            n = 1;
            while (!bus.out_valid && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("latency", n, 13, 0);
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 400 && sb.size() != 0; c++) @(posedge clk);
        chk("drain_pending", sb.size(), 0, 0);
    endtask

    // Downstream ready: always high, or two-low/one-high when backpressure is on
    initial begin
        int ph;
        ph = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % 3;
            bus.out_ready = bp ? (ph == 2) : 1'b1;
        end
    end

    // Monitor: pops one expectation per accepted bin and checks stalled outputs stay put
    initial begin
        exp_t e;
        bit   stalled;
        int   h_re, h_im, h_last;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("stall_valid", int'(bus.out_valid), 1, 0);
                    chk("stall_real", $signed(bus.out_real), h_re, 0);
                    chk("stall_imag", $signed(bus.out_imag), h_im, 0);
                    chk("stall_last", int'(bus.out_last), h_last, 0);
                end
                stalled = bus.out_valid && !bus.out_ready;
                h_re    = $signed(bus.out_real);
                h_im    = $signed(bus.out_imag);
                h_last  = int'(bus.out_last);
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) chk("unexpected_output", 1, 0, 0);
                    else begin
                        e = sb.pop_front();
                        chk("out_real", $signed(bus.out_real), e.re, e.tol);
                        chk("out_imag", $signed(bus.out_imag), e.im, e.tol);
                        chk("out_last", int'(bus.out_last), int'(e.last), 0);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int z[N], imp[N], dc[N], alt[N], d2[N], inv8[N];
        int all1k[N], all8k[N], dc_out[N], dc_s1[N], alt_out[N], d2_re[N], d2_im[N];
        z       = '{0, 0, 0, 0, 0, 0, 0, 0};
        imp     = '{1000, 0, 0, 0, 0, 0, 0, 0};
        dc      = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
        alt     = '{1000, 0, -1000, 0, 1000, 0, -1000, 0};
        d2      = '{0, 0, 1000, 0, 0, 0, 0, 0};
        inv8    = '{8000, 0, 0, 0, 0, 0, 0, 0};
        all1k   = dc;
        all8k   = '{8000, 8000, 8000, 8000, 8000, 8000, 8000, 8000};
        dc_out  = inv8;
        dc_s1   = imp;
        alt_out = '{0, 0, 4000, 0, 0, 0, 4000, 0};
        d2_re   = '{1000, 0, -1000, 0, 1000, 0, -1000, 0};
        d2_im   = '{0, -1000, 0, 1000, 0, -1000, 0, 1000};

        bus.in_valid = 1'b0;
        bus.in_real  = '0;
        bus.in_imag  = '0;
        bus.inverse  = 1'b0;
        bus.scale    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 1, 0);
        chk("rst_out_valid", int'(bus.out_valid), 0, 0);
        chk("rst_out_last", int'(bus.out_last), 0, 0);
        chk("rst_busy", int'(bus.busy), 0, 0);
        chk("rst_out_real", $signed(bus.out_real), 0, 0);
        chk("rst_out_imag", $signed(bus.out_imag), 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        push_exp(all1k, z, 0);
        send(imp, z, 1'b0, 1'b0, 1'b1);
        drain();

        push_exp(dc_out, z, 0);
        send(dc, z, 1'b0, 1'b0, 1'b0);
        drain();

        push_exp(dc_s1, z, 0);
        send(dc, z, 1'b0, 1'b1, 1'b0);
        drain();

        push_exp(alt_out, z, 1);
        send(alt, z, 1'b0, 1'b0, 1'b0);
        drain();

        push_exp(all8k, z, 0);
        send(inv8, z, 1'b1, 1'b0, 1'b0);
        drain();

        push_exp(all1k, z, 0);
        send(inv8, z, 1'b1, 1'b1, 1'b0);
        drain();

        bp = 1'b1;
        push_exp(d2_re, d2_im, 0);
        send(d2, z, 1'b0, 1'b0, 1'b0);
        drain();
        bp = 1'b0;

        send(dc, z, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("busy_in_calc", int'(bus.busy), 1, 0);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", int'(bus.out_valid), 0, 0);
        chk("midrst_busy", int'(bus.busy), 0, 0);
        chk("midrst_in_ready", int'(bus.in_ready), 1, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        push_exp(dc_out, z, 0);
        send(dc, z, 1'b0, 1'b0, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
